// File: rtl/register_file.sv
// Eight-entry datapath register file (R1-R4, S1-S4) with per-register FunSel ops and two async read ports.
// Optional macro RF_SAT_EN: saturating increment/decrement instead of modulo wrap. WIDTH must be >= 16.
module register_file #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       FunSel,
  input  logic [3:0]       RegSel,
  input  logic [3:0]       ScrSel,
  input  logic [2:0]       OutASel,
  input  logic [2:0]       OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB
);

  localparam int NREG = 8;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    FS_DEC    = 3'b000,
    FS_INC    = 3'b001,
    FS_LOAD   = 3'b010,
    FS_CLEAR  = 3'b011,
    FS_CLR_LO = 3'b100,
    FS_LD_LO  = 3'b101,
    FS_LD_HI  = 3'b110,
    FS_SEXT   = 3'b111
  } fun_e;

  logic [WIDTH-1:0] rf_q [NREG];
  logic [WIDTH-1:0] rf_d [NREG];
  logic [NREG-1:0]  wr_en;

  function automatic logic [WIDTH-1:0] apply_fun(input logic [2:0] fs,
                                                 input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] din);
    logic [WIDTH-1:0] r;
    r = cur;
    case (fun_e'(fs))
      FS_DEC: begin
`ifdef RF_SAT_EN
        r = (cur == '0) ? cur : cur - ONE;
`else
        r = cur - ONE;
`endif
      end
      FS_INC: begin
`ifdef RF_SAT_EN
        r = (cur == '1) ? cur : cur + ONE;
`else
        r = cur + ONE;
`endif
      end
      FS_LOAD:   r = din;
      FS_CLEAR:  r = '0;
      FS_CLR_LO: begin
        r      = '0;
        r[7:0] = din[7:0];
      end
      FS_LD_LO:  r[7:0]  = din[7:0];
      FS_LD_HI:  r[15:8] = din[7:0];
      FS_SEXT:   r = {{(WIDTH-8){din[7]}}, din[7:0]};
      default:   r = cur;
    endcase
    return r;
  endfunction

  // Index 0-3 = R1-R4, 4-7 = S1-S4; select bit 3 maps to the lowest index of each bank.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      wr_en[k]     = ~RegSel[3-k];
      wr_en[k + 4] = ~ScrSel[3-k];
    end
  end

  always_comb begin
    for (int k = 0; k < NREG; k++) begin
      rf_d[k] = rf_q[k];
      if (wr_en[k]) rf_d[k] = apply_fun(FunSel, rf_q[k], I);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < NREG; k++) rf_q[k] <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) rf_q[k] <= rf_d[k];
    end
  end

  assign OutA = rf_q[OutASel];
  assign OutB = rf_q[OutBSel];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: a reference model predicts every register, reads are compared via queue.
module tb_register_file;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] I;
  logic [2:0]  FunSel;
  logic [3:0]  RegSel;
  logic [3:0]  ScrSel;
  logic [2:0]  OutASel;
  logic [2:0]  OutBSel;
  logic [15:0] OutA;
  logic [15:0] OutB;

  register_file #(.WIDTH(16)) dut (
    .Clock(Clock), .Reset(Reset), .I(I), .FunSel(FunSel), .RegSel(RegSel),
    .ScrSel(ScrSel), .OutASel(OutASel), .OutBSel(OutBSel), .OutA(OutA), .OutB(OutB)
  );

  always #5 Clock = ~Clock;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] model [8];
  logic [15:0] exp_q [$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_next(input logic [2:0] fs, input logic [15:0] v,
                                           input logic [15:0] d);
    case (fs)
`ifdef RF_SAT_EN
      3'd0: return (v == 16'h0000) ? 16'h0000 : v - 16'd1;
      3'd1: return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
`else
      3'd0: return v - 16'd1;
      3'd1: return v + 16'd1;
`endif
      3'd2: return d;
      3'd3: return 16'h0000;
      3'd4: return {8'h00, d[7:0]};
      3'd5: return {v[15:8], d[7:0]};
      3'd6: return {d[7:0], v[7:0]};
      default: return {{8{d[7]}}, d[7:0]};
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) model[k] = 16'h0000;
  endtask

  // Apply one operation on one rising edge, then disable all writes.
  task automatic do_op(input logic [2:0] fs, input logic [15:0] din,
                       input logic [3:0] rsel, input logic [3:0] ssel);
    @(negedge Clock);
    FunSel = fs; I = din; RegSel = rsel; ScrSel = ssel;
    @(posedge Clock);
    #1;
    RegSel = 4'hF; ScrSel = 4'hF;
    for (int k = 0; k < 4; k++) begin
      if (!rsel[3-k]) model[k]     = ref_next(fs, model[k], din);
      if (!ssel[3-k]) model[k + 4] = ref_next(fs, model[k + 4], din);
    end
  endtask

  task automatic read_all(input string tag);
    logic [15:0] ea, eb;
    for (int k = 0; k < 8; k++) begin
      OutASel = 3'(k);
      OutBSel = 3'(7 - k);
      exp_q.push_back(model[k]);
      exp_q.push_back(model[7 - k]);
      #1;
      ea = exp_q.pop_front();
      eb = exp_q.pop_front();
      check({tag, "_a"}, OutA, ea);
      check({tag, "_b"}, OutB, eb);
    end
  endtask

  task automatic read_one(input string tag, input int idx, input logic [15:0] exp);
    logic [15:0] e;
    OutASel = 3'(idx);
    exp_q.push_back(exp);
    #1;
    e = exp_q.pop_front();
    check(tag, OutA, e);
  endtask

  initial begin
    logic [15:0] pre;
    Reset = 1'b1; I = 16'hFFFF; FunSel = 3'b001; RegSel = 4'h0; ScrSel = 4'h0;
    OutASel = 3'd0; OutBSel = 3'd7;
    model_reset();
    // Active selects during reset must be ignored across several edges.
    repeat (3) @(posedge Clock);
    #1;
    read_all("rst_hold");
    @(negedge Clock);
    RegSel = 4'hF; ScrSel = 4'hF;
    Reset = 1'b0;
    read_all("rst_state");

    // Load R1/R4 only; R2/R3 preloaded and must hold; no write-through.
    do_op(3'b010, 16'h5555, 4'b1011, 4'hF);
    do_op(3'b010, 16'h7777, 4'b1101, 4'hF);
    @(negedge Clock);
    I = 16'h1234; FunSel = 3'b010; RegSel = 4'b0110; ScrSel = 4'hF;
    OutASel = 3'd0; OutBSel = 3'd3;
    #1;
    check("no_wt_a", OutA, 16'h0000);
    check("no_wt_b", OutB, 16'h0000);
    @(posedge Clock);
    #1;
    RegSel = 4'hF;
    model[0] = 16'h1234; model[3] = 16'h1234;
    read_one("r1_load", 0, 16'h1234);
    read_one("r4_load", 3, 16'h1234);
    read_one("r2_hold", 1, 16'h5555);
    read_one("r3_hold", 2, 16'h7777);
    read_all("load_sweep");

    // Byte-field ops on R2.
    do_op(3'b010, 16'hABCD, 4'b1011, 4'hF);
    do_op(3'b101, 16'h0085, 4'b1011, 4'hF);
    read_one("ld_lo", 1, 16'hAB85);
    do_op(3'b110, 16'h0085, 4'b1011, 4'hF);
    read_one("ld_hi", 1, 16'h8585);
    do_op(3'b111, 16'h0085, 4'b1011, 4'hF);
    read_one("sext", 1, 16'hFF85);
    do_op(3'b100, 16'h0085, 4'b1011, 4'hF);
    read_one("clr_lo", 1, 16'h0085);
    do_op(3'b111, 16'h1234, 4'b1011, 4'hF);
    read_one("sext_pos", 1, 16'h0034);

    // Wrap / saturation boundaries on S1 and S2.
    do_op(3'b010, 16'hFFFF, 4'hF, 4'b0111);
    do_op(3'b010, 16'h0000, 4'hF, 4'b1011);
    do_op(3'b001, 16'h0000, 4'hF, 4'b0111);
    do_op(3'b000, 16'h0000, 4'hF, 4'b1011);
`ifdef RF_SAT_EN
    read_one("s1_inc_bound", 4, 16'hFFFF);
    read_one("s2_dec_bound", 5, 16'h0000);
`else
    read_one("s1_inc_bound", 4, 16'h0000);
    read_one("s2_dec_bound", 5, 16'hFFFF);
`endif
    do_op(3'b001, 16'h0000, 4'hF, 4'b1011);
    read_all("incdec_sweep");

    // Multi-register update, each from its own prior value.
    do_op(3'b010, 16'h00F0, 4'h0, 4'h0);
    do_op(3'b001, 16'h0000, 4'b0101, 4'b1010);
    read_all("multi_inc");

    // Clear everything at once; both ports on R4.
    do_op(3'b011, 16'hBEEF, 4'h0, 4'h0);
    read_all("clear_all");
    OutASel = 3'd3; OutBSel = 3'd3;
    exp_q.push_back(16'h0000);
    #1;
    pre = exp_q.pop_front();
    check("same_sel_a", OutA, pre);
    check("same_sel_b", OutB, OutA);

    // Random operations.
    for (int n = 0; n < 40; n++) begin
      do_op(3'($urandom_range(0, 7)), 16'($urandom), 4'($urandom), 4'($urandom));
      read_all("rand");
    end

    // Mid-run async reset, between edges, with writes pending.
    do_op(3'b010, 16'hC3C3, 4'h0, 4'h0);
    @(negedge Clock);
    FunSel = 3'b001; RegSel = 4'h0; ScrSel = 4'h0;
    OutASel = 3'd0; OutBSel = 3'd7;
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    check("async_rst_a", OutA, 16'h0000);
    check("async_rst_b", OutB, 16'h0000);
    @(posedge Clock);
    #1;
    read_all("rst_pending");
    @(negedge Clock);
    RegSel = 4'hF; ScrSel = 4'hF;
    Reset = 1'b0;
    do_op(3'b001, 16'h0000, 4'b0111, 4'hF);
    read_all("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the data width of every register, I, OutA and OutB.
REQ-002 The block SHALL have port Clock, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port I, input, WIDTH, the load data, normally the ALUOut / memory bus.
REQ-005 The block SHALL have port FunSel, input, 3, the operation applied to every selected register.
REQ-006 The block SHALL have port RegSel, input, 4, active-low write enables for R1..R4 (bit 3 = R1, bit 0 = R4).
REQ-007 The block SHALL have port ScrSel, input, 4, active-low write enables for S1..S4 (bit 3 = S1, bit 0 = S4).
REQ-008 The block SHALL have port OutASel, input, 3, the ALU A-operand source: 0-3 = R1-R4, 4-7 = S1-S4.
REQ-009 The block SHALL have port OutBSel, input, 3, the ALU B-operand source, encoded as OutASel.
REQ-010 The block SHALL have port OutA, output, WIDTH, the selected register feeding ALU input A.
REQ-011 The block SHALL have port OutB, output, WIDTH, the selected register feeding ALU input B.

Function
REQ-012 The block SHALL hold eight WIDTH-bit registers, R1-R4 and S1-S4.
REQ-013 On a Clock rising edge, each register whose select bit is 0 SHALL apply FunSel.
- 000 decrement
- 001 increment
- 010 load I
- 011 clear to 0
- 100 clear, then load I[7:0] into bits [7:0]
- 101 load I[7:0] into [7:0], keeping [WIDTH-1:8]
- 110 load I[7:0] into [15:8], keeping [7:0]
- 111 load sign-extended I[7:0]
REQ-014 Registers whose select bit is 1 SHALL hold their value.
REQ-015 Any number of registers SHALL update in the same cycle; each applies FunSel to its own prior value.
REQ-016 OutA and OutB SHALL be combinational reads with zero latency; a write is visible starting the cycle after the edge (no write-through).
REQ-017 OutA and OutB SHALL be allowed to select the same register simultaneously.
REQ-018 Increment/decrement SHALL wrap modulo 2^WIDTH unless RF_SAT_EN is defined.

Reset
REQ-019 Reset=1 SHALL immediately force all eight registers to 0, independent of Clock, so OutA = OutB = 0.
REQ-020 While Reset=1, all FunSel and select inputs SHALL be ignored; the first update occurs on the first rising edge after Reset falls.
REQ-021 Reset asserted mid-sequence SHALL discard all in-progress updates with no partial writes.

Configuration
REQ-022 With RF_SAT_EN defined, increment SHALL saturate at 2^WIDTH-1 and decrement SHALL saturate at 0.
REQ-023 Without RF_SAT_EN, increment of all-ones SHALL yield 0 and decrement of 0 SHALL yield all-ones.

Verification
REQ-024 Reset pulse mid-run, then OutASel=0, OutBSel=7 -> OutA=0x0000 and OutB=0x0000 immediately, before any clock edge.
REQ-025 I=0x1234, FunSel=010, RegSel=0110, ScrSel=1111, one edge -> R1=R4=0x1234 and R2=R3 unchanged; OutA shows 0x1234 only after the edge.
REQ-026 R2=0xABCD, I=0x0085, FunSel=101 -> 0xAB85; then FunSel=110 -> 0x8585; then FunSel=111 -> 0xFF85; then FunSel=100 -> 0x0085.
REQ-027 S1=0xFFFF with FunSel=001, and S2=0x0000 with FunSel=000 -> without RF_SAT_EN, S1=0x0000 and S2=0xFFFF; with RF_SAT_EN, S1=0xFFFF and S2=0x0000.
REQ-028 All eight selects active, FunSel=011 -> all registers 0 after one edge; OutASel=OutBSel=3 -> OutA=OutB=R4.
